// File: rtl/hilo_muldiv_unit.sv
// HI/LO owning multiply/divide unit: iterative shift-add multiply and restoring
// divide on operand magnitudes, sign-corrected in FINISH; MTHI/MTLO write directly.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p_hi, p_lo, m_q, a_q;
  logic             is_div_q, neg_q, rem_neg_q, b_zero_q;

  // Handshake: start acts as valid and "state == IDLE" as ready; a request is
  // taken only on an edge where both hold and flush is low. No queueing.
  logic accept, accept_iter, accept_mt;
  assign accept      = (state == IDLE) && start && !flush;
  assign accept_iter = accept && !op[2];
  assign accept_mt   = accept && (op == 3'd4 || op == 3'd5);

  // Ops 0 and 2 are the signed variants.
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sa    = ~op[0] & a[WIDTH-1];
  assign sb    = ~op[0] & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // Multiply: {p_hi,p_lo} holds partial product above the remaining multiplier bits.
  // Divide:   p_hi is the partial remainder, p_lo shifts dividend out / quotient in.
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic           div_ok;
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_q} : '0);
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ok    = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;
  always_comb begin
    prod     = {p_hi, p_lo};
    prod_fix = neg_q ? -prod : prod;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_neg_q ? -p_hi : p_hi;
        res_lo = neg_q ? -p_lo : p_lo;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_iter) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      m_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (flush) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept_iter) begin
              busy      <= 1'b1;
              cnt       <= '0;
              is_div_q  <= op[1];
              neg_q     <= sa ^ sb;
              rem_neg_q <= sa;
              b_zero_q  <= (b == '0);
              a_q       <= a;
              p_hi      <= '0;
              m_q       <= op[1] ? mag_b : mag_a;
              p_lo      <= op[1] ? mag_a : mag_b;
            end else if (accept_mt) begin
              if (op[0]) lo <= a;
              else       hi <= a;
              done <= 1'b1;
            end
          end
          RUN: begin
            cnt <= cnt + CNT_W'(1);
            if (is_div_q) begin
              p_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              p_lo <= {p_lo[WIDTH-2:0], div_ok};
            end else begin
              p_hi <= mul_sum[WIDTH:1];
              p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
          end
          FINISH: begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
            busy <= 1'b0;
            cnt  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule
